// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the pipeline memory stage (master) and the
// data-memory responder (slave).
interface data_memory_responder_if;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [3:0]  req_byte_en;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_addr, req_byte_en, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_byte_en, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: one outstanding request, LATENCY wait states, byte-lane RAM.
// Optional macro DATA_MEMORY_WRITE_READBACK_EN returns the merged word on write responses.
module data_memory_responder #(
   parameter int WORDS   = 1024,
   parameter int LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   data_memory_responder_if.slave  bus
);
   localparam int         IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam bit         ZERO_LAT = (LATENCY == 0);
   localparam logic [2:0] LOAD     = ZERO_LAT ? 3'd0 : 3'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n;
   logic        accept, enter_resp, mem_we;

   logic        cap_write;
   logic [29:0] cap_idx;
   logic [3:0]  cap_be;
   logic [31:0] cap_wdata;

   logic        op_write, in_range;
   logic [29:0] op_idx;
   logic [3:0]  op_be;
   logic [31:0] op_wdata, old_word, merged, wr_readback;

   logic [31:0] rdata_q;
   logic        error_q;
   logic        unused_addr_bits;

   logic [31:0] mem [WORDS];

   assign unused_addr_bits = ^bus.req_addr[1:0];

   assign bus.req_ready  = (state != WAIT);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_error = error_q;
   assign accept         = bus.req_valid && bus.req_ready;

   // With zero wait states the response is produced on the accept edge itself,
   // so the live request fields are used instead of the captured copy.
   always_comb begin
      op_write = ZERO_LAT ? bus.req_write       : cap_write;
      op_idx   = ZERO_LAT ? bus.req_addr[31:2]  : cap_idx;
      op_be    = ZERO_LAT ? bus.req_byte_en     : cap_be;
      op_wdata = ZERO_LAT ? bus.req_wdata       : cap_wdata;
      in_range = ({2'b00, op_idx} < 32'(WORDS));
      old_word = mem[op_idx[IDX_W-1:0]];
      merged   = old_word;
      for (int i = 0; i < 4; i++) begin
         if (op_be[i]) merged[8*i +: 8] = op_wdata[8*i +: 8];
      end
   end

`ifdef DATA_MEMORY_WRITE_READBACK_EN
   assign wr_readback = merged;
`else
   assign wr_readback = '0;
`endif

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      enter_resp = 1'b0;
      unique case (state)
         IDLE, RESP: begin
            if (accept) begin
               if (ZERO_LAT) begin
                  state_n    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_n = WAIT;
                  cnt_n   = LOAD;
               end
            end else begin
               state_n = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               state_n    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         cap_write <= 1'b0;
         cap_idx   <= '0;
         cap_be    <= '0;
         cap_wdata <= '0;
         rdata_q   <= '0;
         error_q   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            cap_write <= bus.req_write;
            cap_idx   <= bus.req_addr[31:2];
            cap_be    <= bus.req_byte_en;
            cap_wdata <= bus.req_wdata;
         end
         if (enter_resp) begin
            error_q <= !in_range;
            if (!in_range)     rdata_q <= '0;
            else if (op_write) rdata_q <= wr_readback;
            else               rdata_q <= old_word;
         end
      end
   end

   assign mem_we = enter_resp && op_write && in_range && !reset;

   // NOTE: the array is deliberately not reset; it must map to block/distributed RAM and keep contents across reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[op_idx[IDX_W-1:0]] <= merged;
   end
endmodule
